load_store_reg: RTL and testbench

- Parameterised load/store (hold) register with a synchronous active-low clear and a synchronous load strobe; default width is 4 bits.
- Used as a general datapath holding register: it captures `in` when `set` is asserted, keeps its value otherwise, and is zeroed by `clr` or reset.
- Output comes straight from the storage flops; there is no combinational path from any input to `out`.

---
 rtl/ls_reg_pkg.sv | 31 +++
 rtl/ls_reg_ctrl.sv | 16 +
 rtl/load_store_reg.sv | 62 ++++++
 tb/tb_load_store_reg.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ls_reg_pkg.sv
// Shared types and helpers for the load/store holding register.
// Operation encoding, default width, and the clr/set decode are shared by the
// register and any reference model.
package ls_reg_pkg;

    typedef enum logic [1:0] {
        LS_CLEAR = 2'd0,
        LS_HOLD  = 2'd1,
        LS_LOAD  = 2'd2
    } ls_op_e;

    localparam int LS_REG_DEFAULT_WIDTH = 4;

    // Decode the synchronous controls into a register operation.
    // Reset is applied by the register itself, ahead of this decode.
    // The first argument therefore does not influence the result.
    // Clear (active-low) outranks load.
    function automatic ls_op_e ls_decode(input logic rst_unused,
                                         input logic clr,
                                         input logic set);
        ls_op_e op;
        if (!clr)
            op = LS_CLEAR;
        else if (set)
            op = LS_LOAD;
        else
            op = LS_HOLD;
        return op;
    endfunction

endpackage

// File: rtl/ls_reg_ctrl.sv
// Purely combinational control decode for load_store_reg.
// Maps clr and set onto the register operation.
module ls_reg_ctrl
    import ls_reg_pkg::*;
(
    input  logic   clr,
    input  logic   set,
    output ls_op_e op
);

    // Clear beats load, and load beats hold.
    always_comb begin
        op = ls_decode(1'b0, clr, set);
    end

endmodule

// File: rtl/load_store_reg.sv
// load_store_reg: parameterised holding register.
// It has a synchronous active-high reset, an active-low clear and a load strobe.
// Optional feature: define LS_REG_PARITY_EN to add a registered even-parity output, out_par.
// The output is driven directly from flops; no input reaches out combinationally.
module load_store_reg
    import ls_reg_pkg::*;
#(
    parameter int               WIDTH       = LS_REG_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             set,
    input  logic             clr,
    output logic [WIDTH-1:0] out
`ifdef LS_REG_PARITY_EN
    ,
    output logic             out_par
`endif
);

    ls_op_e           op;
    logic [WIDTH-1:0] next_val;

    ls_reg_ctrl u_ctrl (
        .clr (clr),
        .set (set),
        .op  (op)
    );

    // Value the register takes on the next edge when not in reset.
    always_comb begin
        next_val = out;
        case (op)
            LS_CLEAR: next_val = '0;
            LS_LOAD:  next_val = in;
            LS_HOLD:  next_val = out;
            default:  next_val = out;
        endcase
    end

    // Storage register; reset outranks every other operation.
    always_ff @(posedge clk) begin
        if (rst)
            out <= RESET_VALUE;
        else
            out <= next_val;
    end

`ifdef LS_REG_PARITY_EN
    // Parity flop tracks the parity of the value going into out.
    // It therefore always equals ^out without a combinational path.
    always_ff @(posedge clk) begin
        if (rst)
            out_par <= ^RESET_VALUE;
        else
            out_par <= ^next_val;
    end
`endif

endmodule

// File: tb/tb_load_store_reg.sv
// Directed testbench for load_store_reg with the default configuration: WIDTH=4, RESET_VALUE=0.
// Inputs are driven on falling edges. Outputs are checked 2 ns after each rising edge.
module tb_load_store_reg;
    import ls_reg_pkg::*;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] in;
    logic         set;
    logic         clr;
    logic [W-1:0] out;
`ifdef LS_REG_PARITY_EN
    logic         out_par;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] model;
    logic [5:0]   cnt;
    logic [W-1:0] exp_v;

    load_store_reg dut (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .set     (set),
        .clr     (clr),
        .out     (out)
`ifdef LS_REG_PARITY_EN
        ,
        .out_par (out_par)
`endif
    );

    // Clock: 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply one set of inputs on the falling edge
    task automatic drive(input logic r, input logic c, input logic s, input logic [W-1:0] d);
        @(negedge clk);
        rst = r;
        clr = c;
        set = s;
        in  = d;
    endtask

    // Wait for the capturing edge and settle
    task automatic edge_settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b1;
        set = 1'b1;
        in  = 4'hF;

        // Reset held for two edges while load is requested
        edge_settle();
        edge_settle();
        check("reset", out, 4'h0);

        // Release reset with clr low: stays zero
        drive(1'b0, 1'b0, 1'b1, 4'hF);
        edge_settle();
        check("reset_release_clr", out, 4'h0);

        // Load sweep: back-to-back loads at full rate
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 1'b1, 4'(i));
            edge_settle();
            check("load_sweep", out, 4'(i));
        end

        // Hold while in toggles
        drive(1'b0, 1'b1, 1'b1, 4'h5);
        edge_settle();
        check("hold_load", out, 4'h5);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 1'b0, 4'(i));
            edge_settle();
            check("hold", out, 4'h5);
        end

        // Clear beats load
        drive(1'b0, 1'b1, 1'b1, 4'hC);
        edge_settle();
        check("clr_pre_load", out, 4'hC);
        drive(1'b0, 1'b0, 1'b1, 4'h7);
        edge_settle();
        check("clr_over_load", out, 4'h0);
        drive(1'b0, 1'b0, 1'b0, 4'h9);
        edge_settle();
        check("clr_no_load", out, 4'h0);

        // Reset outranks clear-inactive load
        drive(1'b0, 1'b1, 1'b1, 4'hB);
        edge_settle();
        check("pre_reset_load", out, 4'hB);
        drive(1'b1, 1'b1, 1'b1, 4'h9);
        edge_settle();
        check("reset_over_load", out, 4'h0);

        // Counter sweep against a priority model
        model = 4'h0;
        cnt   = 6'd0;
        for (int i = 0; i < 80; i++) begin
            drive(1'b0, cnt[5], cnt[4], cnt[3:0]);
            case (ls_decode(1'b0, cnt[5], cnt[4]))
                LS_CLEAR: model = 4'h0;
                LS_LOAD:  model = cnt[3:0];
                default:  model = model;
            endcase
            exp_q.push_back(model);
            edge_settle();
            exp_v = exp_q.pop_front();
            check("counter_sweep", out, exp_v);
            cnt = cnt + 6'd1;
        end

`ifdef LS_REG_PARITY_EN
        drive(1'b0, 1'b1, 1'b1, 4'b0111);
        edge_settle();
        check("par_0111", {3'b000, out_par}, 4'h1);
        drive(1'b0, 1'b1, 1'b1, 4'b0110);
        edge_settle();
        check("par_0110", {3'b000, out_par}, 4'h0);
        drive(1'b0, 1'b1, 1'b1, 4'b0001);
        edge_settle();
        check("par_0001", {3'b000, out_par}, 4'h1);
        drive(1'b0, 1'b0, 1'b1, 4'b0111);
        edge_settle();
        check("par_clr", {3'b000, out_par}, 4'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
